bpu_dyn: RTL and testbench
==========================

// Module: bpu_dyn
// PURPOSE
//  Dynamic branch predictor for the ID stage; parametrised successor of the static predictor.
//  - Conditional branches: per-PC BHT of saturating counters, trained by resolved outcomes from EX.
//  - JAL: always predicted taken.
//  - Return-type JALR: predicted from a return-address stack (RAS).
//  - Lookup is combinational. BHT/RAS state and performance counters are sequential.
// PARAMETERS
//  ADDR_W     32  instruction address width
//  BHT_DEPTH  64  BHT entries; power of two, >=2; IDX_W = log2(BHT_DEPTH)
//  CNT_W       2  saturating counter width, >=1
//  RAS_DEPTH   4  RAS entries; power of two, >=2
// PORTS
//  clk               in   1       clock
//  rst               in   1       reset; asynchronous, active-high
//  pc_i              in   ADDR_W  PC of instruction in ID
//  inst_jal_i        in   1       instruction is JAL
//  inst_jalr_i       in   1       instruction is JALR
//  inst_bxx_i        in   1       instruction is conditional branch
//  inst_call_i       in   1       JAL/JALR with rd in {x1,x5}
//  inst_ret_i        in   1       JALR with rs1 in {x1,x5}, rs1!=rd
//  jump_and_branch_imm_i in ADDR_W  sign-extended offset
//  pred_en_i         in   1       ID instruction accepted this cycle (not stalled/flushed)
//  upd_valid_i       in   1       EX resolved a conditional branch this cycle
//  upd_pc_i          in   ADDR_W  PC of resolved branch
//  upd_taken_i       in   1       actual direction
//  upd_mispredict_i  in   1       resolved branch/jump was mispredicted
//  prdt_taken_o      out  1       predicted taken
//  prdt_addr_o       out  ADDR_W  predicted target
//  perf_branch_o     out  32      count of upd_valid_i cycles
//  perf_mispredict_o out  32      count of upd_mispredict_i cycles
// BEHAVIOUR
//  Reset (async, rst=1):
//   - all BHT counters = 2^(CNT_W-1)-1 (weakly not-taken)
//   - RAS count=0, top pointer=0, entries=0; perf counters=0
//   - outputs: prdt_taken_o=0 and prdt_addr_o=pc_i+imm (combinational); perf_*_o=0
//  Index: idx(p) = p[IDX_W+1:2].
//  Prediction (combinational, zero latency; inputs are one-hot or all zero):
//   - inst_jal_i: taken=1, addr=pc_i+imm.
//   - inst_bxx_i: taken=BHT[idx(pc_i)][CNT_W-1], addr=pc_i+imm.
//   - inst_jalr_i & inst_ret_i & RAS count>0: taken=1, addr=RAS top.
//   - other JALR, RAS empty, or no branch type: taken=0, addr=pc_i+imm.
//   - Adds are modulo 2^ADDR_W.
//  BHT update (posedge, upd_valid_i=1): BHT[idx(upd_pc_i)] saturating +1 if upd_taken_i,
//   else saturating -1; holds at 2^CNT_W-1 and at 0.
//  BHT same-cycle read/write to the same index: prediction uses the pre-update value;
//   the update is visible from the next cycle.
//  RAS actions apply only when pred_en_i=1:
//   - push (call only): write pc_i+4 at top+1; top++ (wraps); count=min(count+1,RAS_DEPTH).
//     When full, the oldest entry is overwritten.
//   - pop (ret only, JALR, count>0): top-- (wraps); count--.
//   - pop on empty RAS: no state change.
//   - call & ret together (coroutine): prediction uses old top; top entry is replaced
//     by pc_i+4; pointer and count unchanged.
//   - pred_en_i=0: no RAS change, even if the branch-type inputs are set.
//  RAS is speculative: it is not repaired on mispredict or flush. Loss of accuracy is accepted.
//  Perf counters: each increments by 1 per cycle its input is high; wraps at 2^32.
//  rst asserted mid-operation: all state returns to reset values immediately; no partial update.
// TESTING
//  1 Reset, then bxx at pc=0x100, imm=0xFFFFFFF0 -> taken=0, addr=0xF0.
//  2 Two upd_valid_i taken at pc=0x100, then bxx at 0x100 -> taken=1.
//    Three more taken -> counter holds at 3.
//    Two not-taken updates -> taken=0.
//  3 JAL call at 0x200 (pred_en_i=1), then ret JALR at 0x300 -> taken=1, addr=0x204;
//    second ret with RAS empty -> taken=0.
//  4 Five calls at 0x10,0x20,0x30,0x40,0x50 (RAS_DEPTH=4), then 5 rets
//    -> addrs 0x54,0x44,0x34,0x24, then taken=0.
//  5 upd_valid_i at pc=0x140 in the same cycle as lookup at 0x140
//    -> old prediction this cycle, new value next cycle. Pulse rst mid-sequence
//    -> counters/RAS/perf cleared; perf_branch_o counts exactly the number of upd_valid_i cycles.

Source files
------------

// File: rtl/bpu_dyn.sv
// Dynamic branch predictor for the ID stage.
// The predictor sees each ID instruction and gives a direction and a target in the
// same cycle. Conditional branches use a BHT of saturating counters indexed by PC,
// and EX trains that table. JAL is always predicted taken. A return-type JALR takes
// its target from a speculative return-address stack.
module bpu_dyn #(
    parameter int ADDR_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int CNT_W     = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              inst_jal_i,
    input  logic              inst_jalr_i,
    input  logic              inst_bxx_i,
    input  logic              inst_call_i,
    input  logic              inst_ret_i,
    input  logic [ADDR_W-1:0] jump_and_branch_imm_i,
    input  logic              pred_en_i,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic              upd_mispredict_i,
    output logic              prdt_taken_o,
    output logic [ADDR_W-1:0] prdt_addr_o,
    output logic [31:0]       perf_branch_o,
    output logic [31:0]       perf_mispredict_o
);

    localparam int IDX_W      = $clog2(BHT_DEPTH);
    localparam int PTR_W      = $clog2(RAS_DEPTH);
    localparam int CNT_INIT_I = (2 ** (CNT_W - 1)) - 1;

    // A counter starts one step below the taken threshold (weakly not-taken).
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(CNT_INIT_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PTR_W:0]   RAS_FULL = (PTR_W + 1)'(RAS_DEPTH);

    logic [CNT_W-1:0]  bht [BHT_DEPTH];
    logic [ADDR_W-1:0] ras [RAS_DEPTH];
    logic [PTR_W-1:0]  ras_top;
    logic [PTR_W:0]    ras_cnt;

    logic [IDX_W-1:0]  lk_idx;
    logic [IDX_W-1:0]  upd_idx;
    logic [CNT_W-1:0]  upd_cnt;
    logic [ADDR_W-1:0] imm_target;
    logic [ADDR_W-1:0] link_addr;
    logic [PTR_W-1:0]  ras_top_inc;
    logic [PTR_W-1:0]  ras_top_dec;
    logic              ras_empty;
    logic              ras_full;
    logic              do_call;
    logic              do_ret;

    // Only the index bits of the update PC select a BHT entry.
    logic unused_upd_pc;
    assign unused_upd_pc = ^{upd_pc_i[ADDR_W-1:IDX_W+2], upd_pc_i[1:0]};

    assign lk_idx      = pc_i[IDX_W+1:2];
    assign upd_idx     = upd_pc_i[IDX_W+1:2];
    assign upd_cnt     = bht[upd_idx];
    assign imm_target  = pc_i + jump_and_branch_imm_i;
    assign link_addr   = pc_i + ADDR_W'(4);
    assign ras_top_inc = ras_top + PTR_W'(1);
    assign ras_top_dec = ras_top - PTR_W'(1);
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == RAS_FULL);
    assign do_call     = pred_en_i & inst_call_i;
    assign do_ret      = pred_en_i & inst_jalr_i & inst_ret_i & ~ras_empty;

    // Combinational prediction. The BHT read always sees the value from before this cycle's update.
    always_comb begin
        prdt_taken_o = 1'b0;
        prdt_addr_o  = imm_target;
        if (inst_jal_i) begin
            prdt_taken_o = 1'b1;
        end else if (inst_bxx_i) begin
            prdt_taken_o = bht[lk_idx][CNT_W-1];
        end else if (inst_jalr_i && inst_ret_i && !ras_empty) begin
            prdt_taken_o = 1'b1;
            prdt_addr_o  = ras[ras_top];
        end
    end

    // BHT training from resolved branches. Each counter saturates at both ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                bht[i] <= CNT_INIT;
            end
        end else if (upd_valid_i) begin
            if (upd_taken_i && upd_cnt != CNT_MAX) begin
                bht[upd_idx] <= upd_cnt + CNT_W'(1);
            end else if (!upd_taken_i && upd_cnt != '0) begin
                bht[upd_idx] <= upd_cnt - CNT_W'(1);
            end
        end
    end

    // Speculative RAS. A push onto a full stack overwrites the oldest entry.
    // A call that is also a return replaces the top entry in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ras_top <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras[i] <= '0;
            end
        end else if (do_call && do_ret) begin
            ras[ras_top] <= link_addr;
        end else if (do_call) begin
            ras[ras_top_inc] <= link_addr;
            ras_top          <= ras_top_inc;
            if (!ras_full) begin
                ras_cnt <= ras_cnt + (PTR_W + 1)'(1);
            end
        end else if (do_ret) begin
            ras_top <= ras_top_dec;
            ras_cnt <= ras_cnt - (PTR_W + 1)'(1);
        end
    end

    // Free-running event counters. They wrap at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_branch_o     <= '0;
            perf_mispredict_o <= '0;
        end else begin
            if (upd_valid_i) begin
                perf_branch_o <= perf_branch_o + 32'd1;
            end
            if (upd_mispredict_i) begin
                perf_mispredict_o <= perf_mispredict_o + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_bpu_dyn.sv
// Directed testbench for bpu_dyn. The expected values are computed by hand.
module tb_bpu_dyn;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic        inst_jal_i;
    logic        inst_jalr_i;
    logic        inst_bxx_i;
    logic        inst_call_i;
    logic        inst_ret_i;
    logic [31:0] jump_and_branch_imm_i;
    logic        pred_en_i;
    logic        upd_valid_i;
    logic [31:0] upd_pc_i;
    logic        upd_taken_i;
    logic        upd_mispredict_i;
    logic        prdt_taken_o;
    logic [31:0] prdt_addr_o;
    logic [31:0] perf_branch_o;
    logic [31:0] perf_mispredict_o;

    int n_checks = 0;
    int n_pass   = 0;

    bpu_dyn dut (
        .clk                   (clk),
        .rst                   (rst),
        .pc_i                  (pc_i),
        .inst_jal_i            (inst_jal_i),
        .inst_jalr_i           (inst_jalr_i),
        .inst_bxx_i            (inst_bxx_i),
        .inst_call_i           (inst_call_i),
        .inst_ret_i            (inst_ret_i),
        .jump_and_branch_imm_i (jump_and_branch_imm_i),
        .pred_en_i             (pred_en_i),
        .upd_valid_i           (upd_valid_i),
        .upd_pc_i              (upd_pc_i),
        .upd_taken_i           (upd_taken_i),
        .upd_mispredict_i      (upd_mispredict_i),
        .prdt_taken_o          (prdt_taken_o),
        .prdt_addr_o           (prdt_addr_o),
        .perf_branch_o         (perf_branch_o),
        .perf_mispredict_o     (perf_mispredict_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stop the run if the sequence stalls for any reason.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic clear_inputs();
        pc_i = 32'h0; inst_jal_i = 0; inst_jalr_i = 0; inst_bxx_i = 0;
        inst_call_i = 0; inst_ret_i = 0; jump_and_branch_imm_i = 32'h0;
        pred_en_i = 0; upd_valid_i = 0; upd_pc_i = 32'h0; upd_taken_i = 0;
        upd_mispredict_i = 0;
    endtask

    // Advance one clock and return to a point 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bht_update(input logic [31:0] pc, input logic taken);
        clear_inputs();
        upd_valid_i = 1; upd_pc_i = pc; upd_taken_i = taken;
        step();
        clear_inputs();
    endtask

    task automatic lookup_bxx(input logic [31:0] pc, input logic [31:0] imm);
        clear_inputs();
        inst_bxx_i = 1; pc_i = pc; jump_and_branch_imm_i = imm;
        #1;
    endtask

    task automatic issue_call(input logic [31:0] pc);
        clear_inputs();
        inst_jal_i = 1; inst_call_i = 1; pred_en_i = 1; pc_i = pc;
        jump_and_branch_imm_i = 32'h40;
        #1;
    endtask

    task automatic issue_ret(input logic [31:0] pc, input logic en);
        clear_inputs();
        inst_jalr_i = 1; inst_ret_i = 1; pred_en_i = en; pc_i = pc;
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        clear_inputs();
        step(); step();
        lookup_bxx(32'h100, 32'hFFFF_FFF0);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL reset_taken: got %b expected 0", prdt_taken_o); else n_pass++;
        n_checks++; if (prdt_addr_o !== 32'hF0) $display("FAIL reset_addr: got %h expected 000000f0", prdt_addr_o); else n_pass++;
        n_checks++; if (perf_branch_o !== 32'h0) $display("FAIL reset_perf_branch: got %0d expected 0", perf_branch_o); else n_pass++;
        n_checks++; if (perf_mispredict_o !== 32'h0) $display("FAIL reset_perf_misp: got %0d expected 0", perf_mispredict_o); else n_pass++;
        @(posedge clk); #1 rst = 0;
        clear_inputs();
        step();
    endtask

    task automatic test_bht_train();
        // counter 1 -> 2 -> 3
        bht_update(32'h100, 1'b1);
        bht_update(32'h100, 1'b1);
        lookup_bxx(32'h100, 32'h20);
        n_checks++; if (prdt_taken_o !== 1'b1) $display("FAIL bht_two_taken: got %b expected 1", prdt_taken_o); else n_pass++;
        n_checks++; if (prdt_addr_o !== 32'h120) $display("FAIL bht_addr: got %h expected 00000120", prdt_addr_o); else n_pass++;
        // saturates at 3
        for (int i = 0; i < 3; i++) bht_update(32'h100, 1'b1);
        bht_update(32'h100, 1'b0);
        lookup_bxx(32'h100, 32'h20);
        n_checks++; if (prdt_taken_o !== 1'b1) $display("FAIL bht_saturate_hi: got %b expected 1", prdt_taken_o); else n_pass++;
        bht_update(32'h100, 1'b0);
        lookup_bxx(32'h100, 32'h20);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL bht_two_not_taken: got %b expected 0", prdt_taken_o); else n_pass++;
        // a different index has not been trained
        lookup_bxx(32'h104, 32'h20);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL bht_other_idx: got %b expected 0", prdt_taken_o); else n_pass++;
        // saturate at 0: counter 1 -> 0 -> 0, then +1 gives 1, which is still not taken
        bht_update(32'h100, 1'b0);
        bht_update(32'h100, 1'b0);
        bht_update(32'h100, 1'b1);
        lookup_bxx(32'h100, 32'h20);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL bht_saturate_lo: got %b expected 0", prdt_taken_o); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_jal_ras();
        issue_call(32'h200);
        n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== 32'h240) $display("FAIL jal_pred: got %b/%h expected 1/00000240", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        issue_ret(32'h300, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== 32'h204) $display("FAIL ret_pred: got %b/%h expected 1/00000204", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        issue_ret(32'h300, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b0 || prdt_addr_o !== 32'h300) $display("FAIL ret_empty: got %b/%h expected 0/00000300", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        // A call without pred_en leaves the stack empty.
        issue_call(32'h280);
        pred_en_i = 0;
        step();
        issue_ret(32'h300, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL ras_no_en_push: got %b expected 0", prdt_taken_o); else n_pass++;
        step();
        // A return without pred_en does not pop the stack.
        issue_call(32'h500);
        step();
        issue_ret(32'h300, 1'b0);
        step();
        issue_ret(32'h300, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== 32'h504) $display("FAIL ras_no_en_pop: got %b/%h expected 1/00000504", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_ras_overflow();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'h54; exp_addr[1] = 32'h44; exp_addr[2] = 32'h34; exp_addr[3] = 32'h24;
        for (int i = 1; i <= 5; i++) begin
            issue_call(32'(i * 16));
            step();
        end
        for (int i = 0; i < 4; i++) begin
            issue_ret(32'h900, 1'b1);
            n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== exp_addr[i]) $display("FAIL ras_overflow_pop%0d: got %b/%h expected 1/%h", i, prdt_taken_o, prdt_addr_o, exp_addr[i]); else n_pass++;
            step();
        end
        issue_ret(32'h900, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL ras_overflow_empty: got %b expected 0", prdt_taken_o); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_coroutine();
        issue_call(32'h600);
        step();
        issue_ret(32'h700, 1'b1);
        inst_call_i = 1;
        #1;
        n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== 32'h604) $display("FAIL coroutine_pred: got %b/%h expected 1/00000604", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        issue_ret(32'h710, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b1 || prdt_addr_o !== 32'h704) $display("FAIL coroutine_replace: got %b/%h expected 1/00000704", prdt_taken_o, prdt_addr_o); else n_pass++;
        step();
        issue_ret(32'h710, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL coroutine_count: got %b expected 0", prdt_taken_o); else n_pass++;
        step();
        clear_inputs();
    endtask

    task automatic test_same_cycle();
        lookup_bxx(32'h140, 32'h0);
        upd_valid_i = 1; upd_pc_i = 32'h140; upd_taken_i = 1;
        #1;
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL same_cycle_old: got %b expected 0", prdt_taken_o); else n_pass++;
        step();
        upd_valid_i = 0;
        #1;
        n_checks++; if (prdt_taken_o !== 1'b1) $display("FAIL same_cycle_new: got %b expected 1", prdt_taken_o); else n_pass++;
        clear_inputs();
    endtask

    task automatic test_perf_and_reset();
        // updates so far: 2 + 3 + 2 + 3 in the BHT test, 1 in the same-cycle test
        n_checks++; if (perf_branch_o !== 32'd11) $display("FAIL perf_branch_count: got %0d expected 11", perf_branch_o); else n_pass++;
        clear_inputs();
        upd_mispredict_i = 1;
        step(); step(); step();
        clear_inputs();
        n_checks++; if (perf_mispredict_o !== 32'd3) $display("FAIL perf_misp_count: got %0d expected 3", perf_mispredict_o); else n_pass++;
        issue_call(32'h800);
        step();
        clear_inputs();
        // Assert reset in mid-cycle, with an update pending.
        upd_valid_i = 1; upd_pc_i = 32'h140; upd_taken_i = 1; upd_mispredict_i = 1;
        rst = 1;
        #1;
        n_checks++; if (perf_branch_o !== 32'h0 || perf_mispredict_o !== 32'h0) $display("FAIL midrst_perf: got %0d/%0d expected 0/0", perf_branch_o, perf_mispredict_o); else n_pass++;
        step();
        rst = 0;
        clear_inputs();
        lookup_bxx(32'h140, 32'h0);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL midrst_bht: got %b expected 0", prdt_taken_o); else n_pass++;
        issue_ret(32'h900, 1'b1);
        n_checks++; if (prdt_taken_o !== 1'b0) $display("FAIL midrst_ras: got %b expected 0", prdt_taken_o); else n_pass++;
        n_checks++; if (perf_branch_o !== 32'h0) $display("FAIL midrst_no_partial: got %0d expected 0", perf_branch_o); else n_pass++;
        clear_inputs();
        for (int i = 0; i < 3; i++) bht_update(32'h40, 1'b1);
        step();
        n_checks++; if (perf_branch_o !== 32'd3) $display("FAIL perf_after_rst: got %0d expected 3", perf_branch_o); else n_pass++;
        n_checks++; if (perf_mispredict_o !== 32'd0) $display("FAIL perf_misp_after_rst: got %0d expected 0", perf_mispredict_o); else n_pass++;
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_bht_train();
        test_jal_ras();
        test_ras_overflow();
        test_coroutine();
        test_same_cycle();
        test_perf_and_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
